// File: rtl/spi_pkg.sv
// Shared types and constants for the ADC SPI receive path.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, GAP} spi_rx_state_t;

    localparam int   SPI_WORD_W  = 16;
    localparam logic SPI_CS_IDLE = 1'b1;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_rx_if.sv
// Serial pins plus the word-level valid/ready handshake of the SPI receiver.
interface spi_master_rx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_WORD_W
);
    logic              start;
    logic              miso;
    logic              cs;
    logic              busy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        input  start, miso, rx_ready,
        output cs, busy, rx_data, rx_valid
    );

    modport slave (
        output start, miso, rx_ready,
        input  cs, busy, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_rx_shreg.sv
// MSB-first deserializer; nxt is the value the register takes this edge,
// so the owner can capture a full word on the last bit.
module spi_rx_shreg #(
    parameter int DATA_W = 16
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] nxt
);
    logic [DATA_W-1:0] shift_q, shift_d;

    always_comb begin
        nxt     = en ? {shift_q[DATA_W-2:0], din} : shift_q;
        shift_d = clr ? '0 : nxt;
    end

    always_ff @(posedge sclk) begin
        if (rst) shift_q <= '0;
        else     shift_q <= shift_d;
    end
endmodule

// File: rtl/spi_master_rx.sv
// SPI initiator receive side: frames cs, skips the slave's MSB repeat, shifts in a word.
// Define SPI_RX_AUTO_EN for free-running frames that ignore the start port.
module spi_master_rx
    import spi_pkg::*;
#(
    parameter int DATA_W     = SPI_WORD_W,
    parameter int SKIP_BITS  = 1,
    parameter int GAP_CYCLES = 4
) (
    input  logic            sclk,
    input  logic            rst,
    spi_master_rx_if.master bus
);
    localparam int CNT_W = $clog2(max3(DATA_W, SKIP_BITS, GAP_CYCLES) + 1);
    localparam int SKIP_LAST_I = (SKIP_BITS > 0) ? SKIP_BITS - 1 : 0;
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_LAST_I);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    spi_rx_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sh_clr, sh_en, start_ok;
    logic [DATA_W-1:0] sh_nxt;

    spi_rx_shreg #(.DATA_W(DATA_W)) u_shreg (
        .sclk (sclk),
        .rst  (rst),
        .clr  (sh_clr),
        .en   (sh_en),
        .din  (bus.miso),
        .nxt  (sh_nxt)
    );

    // A new frame may only start once the output slot is free or being drained.
`ifdef SPI_RX_AUTO_EN
    assign start_ok = !rx_valid_q || bus.rx_ready;
`else
    assign start_ok = bus.start && (!rx_valid_q || bus.rx_ready);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        sh_clr     = 1'b0;
        sh_en      = 1'b0;
        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        case (state_q)
            IDLE: if (start_ok) begin
                cs_d    = ~SPI_CS_IDLE;
                cnt_d   = '0;
                sh_clr  = 1'b1;
                state_d = (SKIP_BITS == 0) ? SHIFT : SKIP;
            end
            SKIP: if (cnt_q == SKIP_LAST) begin
                cnt_d   = '0;
                state_d = SHIFT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            SHIFT: begin
                sh_en = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    // Load overrides a same-edge consume of the previous word.
                    rx_data_d  = sh_nxt;
                    rx_valid_d = 1'b1;
                    cs_d       = SPI_CS_IDLE;
                    cnt_d      = '0;
                    state_d    = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: if (cnt_q == GAP_LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cs_q       <= SPI_CS_IDLE;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign bus.cs       = cs_q;
    assign bus.busy     = busy_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
endmodule

// File: tb/tb_spi_master_rx.sv
// Directed bench for spi_master_rx with behavioural ADC slaves (with and without MSB repeat).
module tb_spi_master_rx;
    logic sclk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] word, word0;
    int          pos = 0, pos0 = 0;

    spi_master_rx_if #(.DATA_W(16)) bus ();
    spi_master_rx_if #(.DATA_W(16)) bus0 ();

    spi_master_rx #(.DATA_W(16), .SKIP_BITS(1), .GAP_CYCLES(4)) u_dut (
        .sclk (sclk), .rst (rst), .bus (bus)
    );
    spi_master_rx #(.DATA_W(16), .SKIP_BITS(0), .GAP_CYCLES(4)) u_dut0 (
        .sclk (sclk), .rst (rst), .bus (bus0)
    );

    always #5 sclk = ~sclk;

    function automatic logic sbit(logic [15:0] w, int i);
        return (i >= 0 && i < 16) ? w[i[3:0]] : 1'b0;
    endfunction

    // Slave with INIT edge: first low edge repeats the MSB, then bits 15..0.
    always @(negedge sclk) begin
        if (bus.cs !== 1'b0) begin
            pos      <= 0;
            bus.miso <= word[15];
        end else begin
            bus.miso <= sbit(word, (pos == 0) ? 15 : 16 - pos);
            pos      <= pos + 1;
        end
    end

    // Slave without repeat: bits 15..0 on the first 16 low edges.
    always @(negedge sclk) begin
        if (bus0.cs !== 1'b0) begin
            pos0      <= 0;
            bus0.miso <= word0[15];
        end else begin
            bus0.miso <= sbit(word0, 15 - pos0);
            pos0      <= pos0 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic count_cs_low(output int n);
        n = 0;
        while (bus.cs === 1'b0 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 50) begin
            k++;
            tick();
        end
        check(tag, 32'(k < 50), 32'd1);
    endtask

    initial begin
        int n, m;
        rst = 1'b1;
        bus.start = 1'b0;   bus.rx_ready = 1'b1;
        bus0.start = 1'b0;  bus0.rx_ready = 1'b1;
        word = 16'hA5C3;    word0 = 16'hBEEF;
        repeat (2) tick();
        check("rst_cs",    32'(bus.cs),       32'd1);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data",  32'(bus.rx_data),  32'd0);

`ifdef SPI_RX_AUTO_EN
        word = 16'hFFFF;
        rst = 1'b0;
        n = 0;
        while (bus.rx_valid !== 1'b1 && n < 60) begin n++; tick(); end
        check("auto_w0", 32'(bus.rx_data), 32'hFFFF);
        word = 16'h0000;
        n = 0;
        do begin n++; tick(); end while (bus.rx_valid !== 1'b1 && n < 60);
        check("auto_gap1", 32'(n), 32'd22);
        check("auto_w1", 32'(bus.rx_data), 32'h0000);
        word = 16'h5555;
        n = 0;
        do begin n++; tick(); end while (bus.rx_valid !== 1'b1 && n < 60);
        check("auto_gap2", 32'(n), 32'd22);
        check("auto_w2", 32'(bus.rx_data), 32'h5555);
`else
        rst = 1'b0;
        tick();
        // Basic frame.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        count_cs_low(n);
        check("t1_cs_low", 32'(n), 32'd17);
        check("t1_valid",  32'(bus.rx_valid), 32'd1);
        check("t1_data",   32'(bus.rx_data),  32'hA5C3);
        tick();
        check("t1_valid_pulse", 32'(bus.rx_valid), 32'd0);
        check("t1_busy_gap",    32'(bus.busy),     32'd1);
        wait_idle("t1_idle");

        // Back-pressure: start dropped while word unconsumed.
        word = 16'h8001; bus.rx_ready = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        count_cs_low(n);
        check("t2_cs_low", 32'(n), 32'd17);
        check("t2_data0",  32'(bus.rx_data), 32'h8001);
        wait_idle("t2_idle");
        word = 16'h7FFE;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("t2_ign_cs",    32'(bus.cs),       32'd1);
        check("t2_ign_busy",  32'(bus.busy),     32'd0);
        check("t2_hold_valid",32'(bus.rx_valid), 32'd1);
        check("t2_hold_data", 32'(bus.rx_data),  32'h8001);
        bus.start = 1'b1; bus.rx_ready = 1'b1; tick(); bus.start = 1'b0;
        check("t2_acc_cs",    32'(bus.cs),       32'd0);
        check("t2_consumed",  32'(bus.rx_valid), 32'd0);
        count_cs_low(n);
        check("t2_cs_low2", 32'(n), 32'd17);
        check("t2_data1",   32'(bus.rx_data),  32'h7FFE);
        check("t2_valid1",  32'(bus.rx_valid), 32'd1);
        wait_idle("t2_idle2");

        // Reset on edge 8 of a frame.
        word = 16'hFFFF;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (7) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t3_cs",    32'(bus.cs),       32'd1);
        check("t3_valid", 32'(bus.rx_valid), 32'd0);
        check("t3_data",  32'(bus.rx_data),  32'd0);
        check("t3_busy",  32'(bus.busy),     32'd0);
        word = 16'h1234;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        count_cs_low(n);
        check("t3_cs_low", 32'(n), 32'd17);
        check("t3_data2",  32'(bus.rx_data), 32'h1234);
        wait_idle("t3_idle");

        // start held high: cs-high gap is GAP_CYCLES+1.
        word = 16'h3C5A;
        bus.start = 1'b1; tick();
        count_cs_low(n);
        check("t4_cs_low", 32'(n), 32'd17);
        check("t4_data",   32'(bus.rx_data), 32'h3C5A);
        m = 0;
        while (bus.cs === 1'b1 && m < 40) begin m++; tick(); end
        check("t4_gap", 32'(m), 32'd5);
        bus.start = 1'b0;
        count_cs_low(n);
        check("t4_cs_low2", 32'(n), 32'd17);
        check("t4_data2",   32'(bus.rx_data), 32'h3C5A);
        wait_idle("t4_idle");

        // SKIP_BITS=0 against a slave without the MSB repeat.
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        n = 0;
        while (bus0.cs === 1'b0 && n < 40) begin n++; tick(); end
        check("t6_cs_low", 32'(n), 32'd16);
        check("t6_data",   32'(bus0.rx_data),  32'hBEEF);
        check("t6_valid",  32'(bus0.rx_valid), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
